frame_swap_scheduler: RTL

Parametrised N-buffer frame swap controller. Successor to the fixed double-buffer director. Supports 2–4 frame buffers, with FIFO or mailbox (newest-frame-wins) presentation. Runs on one clock; the VGA vsync and GPU done inputs arrive already synchronous. It decides which buffer the GPU writes, which buffer VGA scans out, and when the GPU is started. It sits between the GPU, the frame_buffer bank and vga_controller.

---
 rtl/frame_swap_scheduler.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_swap_scheduler.sv
// -----------------------------------------------------------------------------
// frame_swap_scheduler
//
// N-buffer (2..4) frame swap controller. Chooses the buffer the GPU renders
// into, the buffer the VGA controller scans out, and when the GPU is started.
// Finished frames are presented either in FIFO order or, in mailbox mode,
// newest-frame-wins (an unshown ready frame is replaced and counted as a drop).
//
// Optional build macro: FRAME_SWAP_STATS_EN
//   defined   -> swap_count / drop_count are live wrapping counters
//   undefined -> no counter registers; both ports read as 0
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous active-low reset
//   enable           in   permits new GPU frame starts
//   vga_vs           in   active-low vsync, already synchronous to clk
//   gpu_done         in   GPU completion level; rising edge = frame finished
//   gpu_we           in   GPU pixel write strobe
//   gpu_start        out  one-cycle GPU start pulse
//   buffer_we        out  one-hot write enable (gpu_we routed to write buffer)
//   write_buffer_num out  buffer the GPU renders into
//   read_buffer_num  out  buffer VGA scans out
//   frame_ready      out  a finished frame is queued for display
//   swap_count       out  displayed-frame swaps
//   drop_count       out  frames discarded in mailbox mode
// -----------------------------------------------------------------------------
module frame_swap_scheduler #(
    parameter int NUM_BUFFERS = 3,
    parameter int MAILBOX     = 0,
    parameter int STATS_W     = 16,
    localparam int IDX_W      = $clog2(NUM_BUFFERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   vga_vs,
    input  logic                   gpu_done,
    input  logic                   gpu_we,
    output logic                   gpu_start,
    output logic [NUM_BUFFERS-1:0] buffer_we,
    output logic [IDX_W-1:0]       write_buffer_num,
    output logic [IDX_W-1:0]       read_buffer_num,
    output logic                   frame_ready,
    output logic [STATS_W-1:0]     swap_count,
    output logic [STATS_W-1:0]     drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RENDER,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] read_reg, read_next;
    logic [IDX_W-1:0] ready_reg, ready_next;
    logic [IDX_W-1:0] write_reg, write_next;
    logic             frame_ready_reg, frame_ready_next;
    logic             vs_reg, done_reg;

    logic             vblank_evt;
    logic             done_evt;
    logic             swap;
    logic [IDX_W-1:0] read_post;
    logic             frame_ready_post;
    logic             to_start;

    logic [NUM_BUFFERS-1:0] free_mask;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;

    // ------------------------------------------------------------------
    // Edge detection on the already-synchronous inputs
    // ------------------------------------------------------------------
    assign vblank_evt = vs_reg & ~vga_vs;
    assign done_evt   = ~done_reg & gpu_done;

    // A vblank with a queued frame swaps display buffers this cycle.
    assign swap = vblank_evt & frame_ready_reg;

    // View of the buffer roles after this cycle's swap, so a simultaneous
    // done is judged against the post-swap situation.
    assign read_post        = swap ? ready_reg : read_reg;
    assign frame_ready_post = frame_ready_reg & ~swap;

    // ------------------------------------------------------------------
    // Free buffer search. A done with no frame queued turns the current
    // write buffer into the ready buffer, so "free" means neither the
    // (post-swap) read buffer nor the current write buffer.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUFFERS; gi++) begin : g_free
            assign free_mask[gi] = (IDX_W'(gi) != read_post) &&
                                   (IDX_W'(gi) != write_reg);
        end
    endgenerate

    // Lowest-index free buffer wins: scan downward so the last hit is lowest.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end
    assign free_found = |free_mask;

    // ------------------------------------------------------------------
    // Write strobe routing (not gated by state)
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_BUFFERS; gi++) begin : g_we
            assign buffer_we[gi] = gpu_we & (write_reg == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state / buffer role logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        read_next        = read_reg;
        ready_next       = ready_reg;
        write_next       = write_reg;
        frame_ready_next = frame_ready_reg;
        to_start         = 1'b0;

        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_START;
            ST_START: state_next = ST_RENDER;
            default:  ;
        endcase

        // Display swap; the old read buffer becomes free.
        if (swap) begin
            read_next = ready_reg;
            case (state_reg)
                ST_HOLD: begin
                    // The frame held in the write buffer becomes the new
                    // ready frame; render into the freed buffer next.
                    ready_next = write_reg;
                    write_next = read_reg;
                    to_start   = 1'b1;
                end
                ST_WAIT: begin
                    frame_ready_next = 1'b0;
                    write_next       = read_reg;
                    to_start         = 1'b1;
                end
                default: frame_ready_next = 1'b0;
            endcase
        end

        // Frame completion is only honoured while rendering.
        if ((state_reg == ST_RENDER) && done_evt) begin
            if (!frame_ready_post) begin
                ready_next       = write_reg;
                frame_ready_next = 1'b1;
                if (free_found) begin
                    write_next = free_idx;
                    to_start   = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end else if (MAILBOX != 0) begin
                // Newest frame replaces the unshown one; the stale ready
                // buffer is recycled as the next render target.
                ready_next = write_reg;
                write_next = ready_reg;
                to_start   = 1'b1;
            end else begin
                state_next = ST_HOLD;
            end
        end

        if (to_start) begin
            state_next = enable ? ST_START : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            read_reg        <= '0;
            ready_reg       <= '0;
            write_reg       <= IDX_W'(1);
            frame_ready_reg <= 1'b0;
            vs_reg          <= 1'b1;
            done_reg        <= 1'b1;
        end else begin
            state_reg       <= state_next;
            read_reg        <= read_next;
            ready_reg       <= ready_next;
            write_reg       <= write_next;
            frame_ready_reg <= frame_ready_next;
            vs_reg          <= vga_vs;
            done_reg        <= gpu_done;
        end
    end

    // Decoded from state so it drops as soon as reset is asserted.
    assign gpu_start        = (state_reg == ST_START);
    assign write_buffer_num = write_reg;
    assign read_buffer_num  = read_reg;
    assign frame_ready      = frame_ready_reg;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef FRAME_SWAP_STATS_EN
    logic [STATS_W-1:0] swap_cnt_reg;
    logic [STATS_W-1:0] drop_cnt_reg;
    logic               drop_evt;

    assign drop_evt = (state_reg == ST_RENDER) & done_evt &
                      frame_ready_post & (MAILBOX != 0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (swap)     swap_cnt_reg <= swap_cnt_reg + STATS_W'(1);
            if (drop_evt) drop_cnt_reg <= drop_cnt_reg + STATS_W'(1);
        end
    end

    assign swap_count = swap_cnt_reg;
    assign drop_count = drop_cnt_reg;
`else
    assign swap_count = '0;
    assign drop_count = '0;
`endif

    // ------------------------------------------------------------------
    // Buffer role invariants
    // ------------------------------------------------------------------
    a_read_ne_write : assert property (@(posedge clk) disable iff (!reset)
        read_reg != write_reg);

    a_read_ne_ready : assert property (@(posedge clk) disable iff (!reset)
        frame_ready_reg |-> (read_reg != ready_reg));

    a_ready_ne_write : assert property (@(posedge clk) disable iff (!reset)
        (frame_ready_reg &&
         !((NUM_BUFFERS == 2) && ((state_reg == ST_HOLD) || (state_reg == ST_WAIT))))
        |-> (ready_reg != write_reg));

endmodule
